// File: rtl/snake_game_ctrl_pkg.sv
// Shared codes for the snake game blocks.
// State, collision and direction encodings plus a score helper.
package snake_game_ctrl_pkg;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_PLAY = 2'b01;
  localparam logic [1:0] GS_OVER = 2'b11;

  localparam logic [1:0] COLL_NONE  = 2'b00;
  localparam logic [1:0] COLL_FATAL = 2'b01;
  localparam logic [1:0] COLL_APPLE = 2'b10;

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'b000,
    DIR_UP    = 3'b001,
    DIR_DOWN  = 3'b010,
    DIR_LEFT  = 3'b011,
    DIR_RIGHT = 3'b100
  } dir_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/snake_game_ctrl_frame_divider.sv
// Counts frame_end ticks modulo N; o_term flags the last count.
// Sync clear has priority over the tick.
module snake_game_ctrl_frame_divider #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_term
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] L_LAST = CW'(N - 1);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == L_LAST);
  assign o_term = w_term;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= w_term ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-state / collision controller beside the snake renderer.
// Accumulates per-frame hit flags, decides at frame_end.
import snake_game_ctrl_pkg::*;

module snake_game_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int BORDER          = 10,
  parameter int FRAMES_PER_MOVE = 8,
  parameter int OVER_FRAMES     = 120,
  parameter int BIT             = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [BIT-1:0] i_x_pos,
  input  logic [BIT-1:0] i_y_pos,
  input  logic           i_frame_end,
  input  logic           i_start,
  input  logic           i_head_active,
  input  logic           i_body_active,
  input  logic           i_apple_active,
  output logic           o_update,
  output logic [1:0]     o_collision,
  output logic [1:0]     o_game_state,
  output logic [7:0]     o_score
);

  localparam logic [BIT-1:0] L_LO  = BIT'(BORDER);
  localparam logic [BIT-1:0] L_XHI = BIT'(H_ACTIVE - BORDER);
  localparam logic [BIT-1:0] L_YHI = BIT'(V_ACTIVE - BORDER);

  logic [1:0] r_state;
  logic [1:0] r_coll;
  logic       r_upd;
  logic [7:0] r_score;
  logic       r_hit_body;
  logic       r_hit_apple;
  logic       r_hit_wall;

  logic w_play;
  logic w_idle;
  logic w_over;
  logic w_in_wall;
  logic w_c_body;
  logic w_c_apple;
  logic w_c_wall;
  logic w_body;
  logic w_apple;
  logic w_wall;
  logic w_fatal;
  logic w_start_go;
  logic w_move_tick;
  logic w_move_clr;
  logic w_move_term;
  logic w_over_tick;
  logic w_over_clr;
  logic w_over_term;

  assign w_play = (r_state == GS_PLAY);
  assign w_idle = (r_state == GS_IDLE);
  assign w_over = (r_state == GS_OVER);

  assign w_in_wall = (i_x_pos <  L_LO)  ||
                     (i_x_pos >= L_XHI) ||
                     (i_y_pos <  L_LO)  ||
                     (i_y_pos >= L_YHI);

  assign w_c_body  = w_play & i_head_active & i_body_active;
  assign w_c_apple = w_play & i_head_active & i_apple_active;
  assign w_c_wall  = w_play & i_head_active & w_in_wall;

  // include the frame_end pixel itself in the decision
  assign w_body  = r_hit_body  | w_c_body;
  assign w_apple = r_hit_apple | w_c_apple;
  assign w_wall  = r_hit_wall  | w_c_wall;
  assign w_fatal = w_body | w_wall;

  always_ff @(posedge clk) begin
    if (reset || i_frame_end) begin
      r_hit_body  <= 1'b0;
      r_hit_apple <= 1'b0;
      r_hit_wall  <= 1'b0;
    end else begin
      r_hit_body  <= w_body;
      r_hit_apple <= w_apple;
      r_hit_wall  <= w_wall;
    end
  end

  assign w_start_go  = i_frame_end & w_idle & i_start;
  assign w_move_tick = i_frame_end & w_play & ~w_fatal & ~w_apple;
  assign w_move_clr  = w_start_go;
  assign w_over_tick = i_frame_end & w_over;
  assign w_over_clr  = i_frame_end & w_play & w_fatal;

  snake_game_ctrl_frame_divider #(
    .N(FRAMES_PER_MOVE)
  ) u_move_div (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_move_clr),
    .i_tick(w_move_tick),
    .o_term(w_move_term)
  );

  snake_game_ctrl_frame_divider #(
    .N(OVER_FRAMES)
  ) u_over_div (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_over_clr),
    .i_tick(w_over_tick),
    .o_term(w_over_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= GS_IDLE;
      r_coll  <= COLL_NONE;
      r_upd   <= 1'b0;
      r_score <= 8'd0;
    end else begin
      r_coll <= COLL_NONE;
      r_upd  <= 1'b0;
      if (i_frame_end) begin
        unique case (1'b1)
          w_idle: begin
            if (i_start) begin
              r_state <= GS_PLAY;
              r_score <= 8'd0;
            end
          end
          w_play: begin
            if (w_fatal) begin
              r_state <= GS_OVER;
              r_coll  <= COLL_FATAL;
            end else if (w_apple) begin
              r_coll  <= COLL_APPLE;
              r_score <= sat_inc8(r_score);
            end else begin
              r_upd <= w_move_term;
            end
          end
          w_over: begin
            if (w_over_term) r_state <= GS_IDLE;
          end
          default: r_state <= GS_IDLE;
        endcase
      end
    end
  end

  assign o_update     = r_upd;
  assign o_collision  = r_coll;
  assign o_game_state = r_state;
  assign o_score      = r_score;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Randomized bench for snake_game_ctrl against a frame-level model.
// Outputs are checked every cycle, 1 time unit after the clock edge.
module tb_snake_game_ctrl;

  localparam int FPM = 8;
  localparam int OVR = 4;

  logic       clk;
  logic       reset;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       frame_end;
  logic       start;
  logic       head;
  logic       body;
  logic       apple;
  logic       upd;
  logic [1:0] coll;
  logic [1:0] gs;
  logic [7:0] score;

  int n_cmp = 0;
  int n_bad = 0;

  int m_state;
  int m_score;
  int m_moves;
  int m_over;
  bit m_hb, m_ha, m_hw;
  int e_coll;
  bit e_upd;
  int n_upd;

  snake_game_ctrl #(
    .FRAMES_PER_MOVE(FPM),
    .OVER_FRAMES    (OVR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_x_pos       (x_pos),
    .i_y_pos       (y_pos),
    .i_frame_end   (frame_end),
    .i_start       (start),
    .i_head_active (head),
    .i_body_active (body),
    .i_apple_active(apple),
    .o_update      (upd),
    .o_collision   (coll),
    .o_game_state  (gs),
    .o_score       (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit fe, input bit st,
                       input int x, input int y,
                       input bit h, input bit b, input bit a);
    bit wall;
    e_upd  = 0;
    e_coll = 0;
    if (rst) begin
      m_state = 0; m_score = 0; m_moves = 0; m_over = 0;
      m_hb = 0; m_ha = 0; m_hw = 0;
      return;
    end
    wall = (x < 10) || (x >= 630) || (y < 10) || (y >= 470);
    if (m_state == 1) begin
      m_hb |= h && b;
      m_ha |= h && a;
      m_hw |= h && wall;
    end
    if (!fe) return;
    case (m_state)
      0: if (st) begin m_state = 1; m_score = 0; m_moves = 0; end
      1: begin
        if (m_hb || m_hw) begin
          m_state = 3; e_coll = 1; m_over = 0;
        end else if (m_ha) begin
          e_coll = 2;
          if (m_score < 255) m_score++;
        end else begin
          m_moves++;
          if (m_moves % FPM == 0) e_upd = 1;
        end
      end
      3: begin
        m_over++;
        if (m_over == OVR) m_state = 0;
      end
      default: ;
    endcase
    m_hb = 0; m_ha = 0; m_hw = 0;
  endtask

  task automatic step(input bit rst, input bit fe, input bit st,
                      input int x, input int y,
                      input bit h, input bit b, input bit a);
    reset = rst; frame_end = fe; start = st;
    x_pos = 10'(x); y_pos = 10'(y);
    head = h; body = b; apple = a;
    model(rst, fe, st, x, y, h, b, a);
    @(posedge clk);
    #1;
    check("state", gs, m_state);
    check("coll", coll, e_coll);
    check("update", upd, e_upd);
    check("score", score, m_score);
    if (upd) n_upd++;
  endtask

  // kind: 0 clean, 1 apple, 2 wall+apple, 3 body, 4 fully random
  task automatic frame(input int kind, input bit st, input int rst_at);
    int n, d, x, y;
    bit h, b, a;
    n = $urandom_range(3, 8);
    d = $urandom_range(0, n);
    for (int i = 0; i <= n; i++) begin
      x = $urandom_range(10, 629);
      y = $urandom_range(10, 469);
      b = $urandom_range(0, 1);
      a = $urandom_range(0, 1);
      h = $urandom_range(0, 1) && !b && !a;
      if (kind == 4) begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
        h = ($urandom_range(0, 3) == 0);
      end else if (i == d && kind != 0) begin
        h = 1;
        b = (kind == 3);
        a = (kind != 3);
        if (kind == 2) x = $urandom_range(0, 9);
      end
      step(i == rst_at, i == n, st, x, y, h, b, a);
    end
    for (int i = 0; i < 2; i++)
      step(0, 0, st, $urandom_range(0, 639), $urandom_range(0, 479),
           0, $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  initial begin
    reset = 1; frame_end = 0; start = 0;
    x_pos = 0; y_pos = 0; head = 0; body = 0; apple = 0;
    n_upd = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1, 1, 1);

    frame(0, 1, -1);
    check("enter_play", gs, 2'b01);

    n_upd = 0;
    for (int f = 0; f < 24; f++) frame(0, $urandom_range(0, 1), -1);
    check("upd_count", n_upd, 3);

    frame(1, 0, -1);
    frame(0, 0, -1);
    check("score_1", score, 1);

    frame(2, 1, -1);
    check("wall_over", gs, 2'b11);

    for (int f = 0; f < OVR - 1; f++) frame(0, 1, -1);
    check("over_hold", gs, 2'b11);
    frame(0, 1, -1);
    check("over_idle", gs, 2'b00);
    frame(0, 1, -1);
    check("replay", gs, 2'b01);

    step(0, 0, 0, 300, 300, 1, 1, 0);
    step(1, 0, 0, 300, 300, 0, 0, 0);
    frame(0, 0, -1);
    check("rst_idle", gs, 2'b00);

    frame(0, 1, -1);
    for (int f = 0; f < 258; f++) frame(1, 0, -1);
    check("score_sat", score, 255);

    for (int f = 0; f < 200; f++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k > 4) k = 0;
      frame(k, $urandom_range(0, 3) == 0,
            ($urandom_range(0, 39) == 0) ? $urandom_range(0, 3) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
